// File: rtl/seg_scan_driver_if.sv
// rtl/seg_scan_driver_if.sv - character codes in, multiplexed 7-segment bus out
interface seg_scan_driver_if;
  logic [4:0] bcd_0;
  logic [4:0] bcd_1;
  logic [4:0] bcd_2;
  logic [4:0] bcd_3;
  logic       blink;
  logic [6:0] seg;
  logic [3:0] an;

  modport master (output bcd_0, bcd_1, bcd_2, bcd_3, blink, input seg, an);
  modport slave  (input bcd_0, bcd_1, bcd_2, bcd_3, blink, output seg, an);
endinterface

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - four-digit scanned 7-segment driver with blanking and blink
// Outputs are registered from next-state values so seg/an reflect the slot being entered.
module seg_scan_driver #(
  parameter int DIGIT_TICKS = 50000,
  parameter int BLANK_TICKS = 1000,
  parameter int BLINK_SCANS = 125
) (
  input  logic               clk,
  input  logic               rst,
  seg_scan_driver_if.slave   disp
);
  localparam int CW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam int BW = $clog2(BLINK_SCANS + 1);
  localparam logic [CW-1:0] LAST_CNT   = CW'(DIGIT_TICKS - 1);
  localparam logic [CW-1:0] BLANK_V    = CW'(BLANK_TICKS);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_SCANS - 1);

  localparam logic [4:0] BCD_A = 5'd10, BCD_B = 5'd11, BCD_D = 5'd12, BCD_F = 5'd13,
                         BCD_G = 5'd14, BCD_L = 5'd15, BCD_N = 5'd16, BCD_O = 5'd17,
                         BCD_R = 5'd18, BCD_T = 5'd19;

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic            phase_q, phase_d;
  logic [3:0][4:0] shadow_q, shadow_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      an_q, an_d;
  logic            scan_start, scan_wrap, lit;
  logic [4:0]      code;
  logic [6:0]      glyph;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      bcnt_q   <= '0;
      phase_q  <= 1'b1;
      shadow_q <= '0;
      seg_q    <= 7'h7F;
      an_q     <= 4'hF;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      bcnt_q   <= bcnt_d;
      phase_q  <= phase_d;
      shadow_q <= shadow_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    bcnt_d     = bcnt_q;
    phase_d    = phase_q;
    shadow_d   = shadow_q;
    scan_start = 1'b0;
    scan_wrap  = 1'b0;

    // IDLE only exists between reset release and the first edge, which opens slot 0.
    if (state_q == S_IDLE) begin
      cnt_d      = '0;
      idx_d      = 2'd0;
      scan_start = 1'b1;
    end else if (cnt_q == LAST_CNT) begin
      cnt_d      = '0;
      idx_d      = idx_q + 2'd1;
      scan_start = (idx_q == 2'd3);
      scan_wrap  = (idx_q == 2'd3);
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (scan_start)
      shadow_d = {disp.bcd_3, disp.bcd_2, disp.bcd_1, disp.bcd_0};

    if (!disp.blink) begin
      bcnt_d  = '0;
      phase_d = 1'b1;
    end else if (scan_wrap) begin
      if (bcnt_q == BLINK_LAST) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end

    state_d = (cnt_d < BLANK_V) ? S_BLANK : S_SHOW;
    lit     = (state_d == S_SHOW) && phase_d;
    code    = shadow_d[idx_d];

    case (code)
      5'd0:    glyph = 7'h40;
      5'd1:    glyph = 7'h79;
      5'd2:    glyph = 7'h24;
      5'd3:    glyph = 7'h30;
      5'd4:    glyph = 7'h19;
      5'd5:    glyph = 7'h12;
      5'd6:    glyph = 7'h02;
      5'd7:    glyph = 7'h78;
      5'd8:    glyph = 7'h00;
      5'd9:    glyph = 7'h10;
      BCD_A:   glyph = 7'h08;
      BCD_B:   glyph = 7'h03;
      BCD_D:   glyph = 7'h21;
      BCD_F:   glyph = 7'h0E;
      BCD_G:   glyph = 7'h42;
      BCD_L:   glyph = 7'h47;
      BCD_N:   glyph = 7'h2B;
      BCD_O:   glyph = 7'h40;
      BCD_R:   glyph = 7'h2F;
      BCD_T:   glyph = 7'h07;
      default: glyph = 7'h7F;
    endcase

    seg_d = lit ? glyph : 7'h7F;
    an_d  = lit ? ~(4'b0001 << idx_d) : 4'hF;
  end

  assign disp.seg = seg_q;
  assign disp.an  = an_q;
endmodule
